// File: rtl/wb_data_seg_p_if.sv
// Memory request port between the write-back data segment and the data memory/cache.
interface wb_data_seg_p_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ADDR_W = 32
);
   localparam int unsigned NB = XLEN / 8;

   logic              mem_req;
   logic [NB-1:0]     mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [XLEN-1:0]   mem_wdata;
   logic              mem_ready;
   logic [XLEN-1:0]   mem_rdata;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_ready,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_ready,
      output mem_rdata
   );
endinterface

// File: rtl/wb_data_seg_p.sv
// MEM/WB write-back data segment: store lane alignment, load extension, miss wait FSM and
// the registered write-back value.
module wb_data_seg_p #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned NB     = XLEN / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bubbleW,
   input  logic              flushW,
   input  logic              wb_select,
   input  logic [2:0]        load_type,
   input  logic [NB-1:0]     store_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [XLEN-1:0]   in_data,
   wb_data_seg_p_if.master   mem,
   output logic [XLEN-1:0]   data_WB,
   output logic              miss,
   output logic              misalign
);
   localparam int unsigned OffW = $clog2(NB);

   localparam logic [2:0] LtLb  = 3'd1;
   localparam logic [2:0] LtLh  = 3'd2;
   localparam logic [2:0] LtLw  = 3'd3;
   localparam logic [2:0] LtLbu = 3'd4;
   localparam logic [2:0] LtLhu = 3'd5;
   localparam logic [2:0] LtLwu = 3'd6;
   localparam logic [2:0] LtLd  = 3'd7;

   typedef enum logic {StIdle, StWait} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        lt_q, lt_d;
   logic              sel_q, sel_d;
   logic [NB-1:0]     we_q, we_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [XLEN-1:0]   data_q, data_d;
   logic [XLEN-1:0]   held_q, held_d;
   logic              held_vld_q, held_vld_d;
   logic              flush_pend_q, flush_pend_d;

   logic [OffW-1:0]   off;
   logic [2:0]        lt_eff;
   logic [2*NB-1:0]   we_wide;
   logic              store_mis, load_mis, mis_live, active, req_live, sel_live;
   logic [XLEN-1:0]   wdata_live;
   logic              upd;
   logic [XLEN-1:0]   val;

   // Pick the addressed lanes out of a full read word and extend them to XLEN.
   function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] rdata,
                                                input logic [2:0]      lt,
                                                input logic [OffW-1:0] o);
      logic [XLEN-1:0] sh;
      sh = rdata >> {o, 3'b000};
      case (lt)
         LtLb:    return XLEN'($signed(sh[7:0]));
         LtLh:    return XLEN'($signed(sh[15:0]));
         LtLw:    return XLEN'($signed(sh[31:0]));
         LtLbu:   return XLEN'(sh[7:0]);
         LtLhu:   return XLEN'(sh[15:0]);
         LtLwu:   return XLEN'(sh[31:0]);
         default: return rdata;
      endcase
   endfunction

   assign off = addr[OffW-1:0];

   // Decode the live access: effective load type, lane alignment and misalignment.
   always_comb begin
      lt_eff = load_type;
      // a 32-bit datapath has no doubleword or unsigned-word loads; both act as LW
      if ((XLEN == 32) && ((load_type == LtLwu) || (load_type == LtLd))) begin
         lt_eff = LtLw;
      end
      we_wide   = {{NB{1'b0}}, store_en} << off;
      store_mis = |we_wide[2*NB-1:NB];
      load_mis  = 1'b0;
      case (lt_eff)
         LtLh, LtLhu: load_mis = off[0];
         LtLw, LtLwu: load_mis = |off[1:0];
         LtLd:        load_mis = |off;
         default:     load_mis = 1'b0;
      endcase
      mis_live   = store_mis | load_mis;
      active     = (load_type != 3'd0) | (|store_en);
      req_live   = rst & active & ~mis_live;
      sel_live   = wb_select & ~mis_live;
      wdata_live = in_data << {off, 3'b000};
   end

   // Memory port: live inputs while idle, latched copies while waiting on a miss.
   always_comb begin
      if (state_q == StWait) begin
         mem.mem_req   = rst;
         mem.mem_we    = we_q;
         mem.mem_addr  = addr_q & ~ADDR_W'(NB - 1);
         mem.mem_wdata = wdata_q;
         miss          = 1'b1;
         misalign      = 1'b0;
      end else begin
         mem.mem_req   = req_live;
         mem.mem_we    = we_wide[NB-1:0];
         mem.mem_addr  = addr & ~ADDR_W'(NB - 1);
         mem.mem_wdata = wdata_live;
         miss          = 1'b0;
         misalign      = mis_live;
      end
   end

   // Next state: wait FSM, request latches, flush-pending and the write-back/park registers.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      lt_d         = lt_q;
      sel_d        = sel_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      data_d       = data_q;
      held_d       = held_q;
      held_vld_d   = held_vld_q;
      flush_pend_d = flush_pend_q;
      upd          = 1'b0;
      val          = '0;

      case (state_q)
         StIdle: begin
            if (req_live && !mem.mem_ready) begin
               state_d = StWait;
               addr_d  = addr;
               lt_d    = lt_eff;
               sel_d   = sel_live;
               we_d    = we_wide[NB-1:0];
               wdata_d = wdata_live;
            end else begin
               upd = 1'b1;
               val = sel_live ? load_ext(mem.mem_rdata, lt_eff, off) : XLEN'(addr);
            end
         end
         StWait: begin
            if (mem.mem_ready) begin
               state_d = StIdle;
               upd     = 1'b1;
               if (flush_pend_q) begin
                  val = '0;
               end else begin
                  val = sel_q ? load_ext(mem.mem_rdata, lt_q, addr_q[OffW-1:0])
                              : XLEN'(addr_q);
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // a flush cannot cancel an issued miss, so remember to discard its data
      if ((state_q == StWait) && mem.mem_ready) begin
         flush_pend_d = 1'b0;
      end else if (flushW && !bubbleW && (state_d == StWait)) begin
         flush_pend_d = 1'b1;
      end

      if (bubbleW) begin
         // park a miss completing under a bubble until the bubble drops
         if (upd && (state_q == StWait)) begin
            held_d     = val;
            held_vld_d = 1'b1;
         end
      end else if (held_vld_q) begin
         data_d     = flushW ? '0 : held_q;
         held_vld_d = 1'b0;
      end else if (flushW) begin
         data_d = '0;
      end else if (upd) begin
         data_d = val;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         lt_q         <= '0;
         sel_q        <= 1'b0;
         we_q         <= '0;
         wdata_q      <= '0;
         data_q       <= '0;
         held_q       <= '0;
         held_vld_q   <= 1'b0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         lt_q         <= lt_d;
         sel_q        <= sel_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         data_q       <= data_d;
         held_q       <= held_d;
         held_vld_q   <= held_vld_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   assign data_WB = data_q;
endmodule
